// File: rtl/abc_div_pkg.sv
// Shared parameters and types for the ABC datapath and its inverse divider.
package ABC_parameter;

  // Operand width of the ABC multiplier-adder. The divider's dividend is 2*WIDTH bits wide.
  localparam int WIDTH = 4;

  // Width of the step counter. It must be able to hold values up to WIDTH.
  localparam int CNT_W = $clog2(WIDTH + 1);

  // Divider control states
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/abc_div_step.sv
// One restoring-division iteration (combinational).
// Shift the next dividend bit into the partial remainder and try to subtract
// the divisor. Keep the difference when it does not go negative.
module abc_div_step
  import ABC_parameter::*;
(
  input  logic [WIDTH:0]   i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH:0]   o_rem,
  output logic             o_qbit
);

  logic [WIDTH:0] w_t;
  logic           w_ge;

  // Trial subtraction. If the remainder's top bit is set, the shifted value is
  // at least 2^(WIDTH+1) and is therefore >= divisor. The W+1-bit modular
  // difference is still exact, because the true difference is < divisor.
  always_comb begin
    w_t  = {i_rem[WIDTH-1:0], i_bit};
    w_ge = i_rem[WIDTH] | (w_t >= {1'b0, i_divisor});
    if (w_ge) begin
      o_rem  = w_t - {1'b0, i_divisor};
      o_qbit = 1'b1;
    end else begin
      o_rem  = w_t;
      o_qbit = 1'b0;
    end
  end

endmodule

// File: rtl/abc_div.sv
// Sequential restoring divider. This is the inverse of ABC's a*b+c:
// dividend = quot*divisor + rem, with rem < divisor.
// The divider produces one quotient bit per clock, MSB first.
// An overflow is flagged immediately when the quotient cannot fit WIDTH bits.
module abc_div
  import ABC_parameter::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 busy,
  output logic                 done,
  output logic                 ovf,
  output logic [WIDTH-1:0]     quot,
  output logic [WIDTH-1:0]     rem
);

  div_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH:0]   r_prem;     // partial remainder, one guard bit
  logic [WIDTH-1:0] r_shift;    // dividend low half out of the MSB, quotient bits in at the LSB
  logic [WIDTH-1:0] r_divisor;
  logic             r_busy;
  logic             r_done;
  logic             r_ovf;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;

  logic [WIDTH:0]   w_rem_next;
  logic             w_qbit;

  abc_div_step u_step (
    .i_rem     (r_prem),
    .i_bit     (r_shift[WIDTH-1]),
    .i_divisor (r_divisor),
    .o_rem     (w_rem_next),
    .o_qbit    (w_qbit)
  );

  // Control FSM, operand capture, iteration registers and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= DIV_IDLE;
      r_cnt     <= {CNT_W{1'b0}};
      r_prem    <= {(WIDTH+1){1'b0}};
      r_shift   <= {WIDTH{1'b0}};
      r_divisor <= {WIDTH{1'b0}};
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ovf     <= 1'b0;
      r_quot    <= {WIDTH{1'b0}};
      r_rem     <= {WIDTH{1'b0}};
    end else begin
      case (r_state)
        DIV_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_divisor <= divisor;
            r_prem    <= {1'b0, dividend[2*WIDTH-1:WIDTH]};
            r_shift   <= dividend[WIDTH-1:0];
            r_cnt     <= {CNT_W{1'b0}};
            r_busy    <= 1'b1;
            // A high half >= divisor means the quotient needs more than WIDTH bits.
            // This also covers divisor == 0.
            if (dividend[2*WIDTH-1:WIDTH] >= divisor) begin
              r_state <= DIV_DONE;
              r_done  <= 1'b1;
              r_ovf   <= 1'b1;
              r_quot  <= {WIDTH{1'b0}};
              r_rem   <= {WIDTH{1'b0}};
            end else begin
              r_state <= DIV_CALC;
              r_ovf   <= 1'b0;
            end
          end
        end
        DIV_CALC: begin
          r_prem  <= w_rem_next;
          r_shift <= {r_shift[WIDTH-2:0], w_qbit};
          r_cnt   <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_state <= DIV_DONE;
            r_done  <= 1'b1;
            r_quot  <= {r_shift[WIDTH-2:0], w_qbit};
            r_rem   <= w_rem_next[WIDTH-1:0];
          end
        end
        DIV_DONE: begin
          r_state <= DIV_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= DIV_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign ovf  = r_ovf;
  assign quot = r_quot;
  assign rem  = r_rem;

endmodule
